// File: rtl/stream_pkg.sv
// Shared stream types for the lane packer and its output stage.
// Lane fill order selects which end of the word receives lane 0.
package stream_pkg;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } lane_order_e;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry output register with valid/ready handshake.
// A load is only issued while rdy_o is high, so a held word is never lost.
module stream_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] pld_i,
    input  logic         rdy_i,
    output logic         vld_o,
    output logic [W-1:0] pld_o,
    output logic         rdy_o
);

    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] pld_q;
    logic [W-1:0] pld_d;

    assign vld_o = vld_q;
    assign pld_o = pld_q;
    assign rdy_o = ~vld_q | rdy_i;

    // Load a new word, or drop the valid once downstream has taken it.
    always_comb begin
        vld_d = vld_q;
        pld_d = pld_q;
        if (load_i) begin
            vld_d = 1'b1;
            pld_d = pld_i;
        end else if (rdy_i) begin
            vld_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            pld_q <= '0;
        end else begin
            vld_q <= vld_d;
            pld_q <= pld_d;
        end
    end

endmodule

// File: rtl/snd_rcv_packer.sv
// Packs N-bit lanes into M-lane words with a run-time lane ratio.
// Words close on a full ratio, on last_in, or on flush_in.
module snd_rcv_packer
    import stream_pkg::*;
#(
    parameter int          N          = 8,
    parameter int          M          = 4,
    parameter lane_order_e LANE_ORDER = LSB_FIRST
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [$clog2(M+1)-1:0] cfg_ratio,
    input  logic                   vld_in,
    input  logic [N-1:0]           data_in,
    input  logic                   last_in,
    output logic                   rdy_out,
    input  logic                   flush_in,
    output logic                   vld_out,
    output logic [M*N-1:0]         data_out,
    output logic [M-1:0]           keep_out,
    output logic                   last_out,
    input  logic                   rdy_in,
    output logic                   busy
);

    localparam int RW = $clog2(M+1);
    localparam int CW = $clog2(M);
    localparam int W  = M*N;
    localparam int PW = W + M + 1;
    localparam logic [RW-1:0] RMAX = RW'(M);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [RW-1:0] r_q;
    logic [RW-1:0] r_d;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic [M-1:0]  keep_q;
    logic [M-1:0]  keep_d;

    logic          accept;
    logic [RW-1:0] r_cfg;
    logic [RW-1:0] r_use;
    logic [CW-1:0] idx;
    logic          is_end;
    logic          close;
    logic          flush_only;
    logic          load;
    logic [W-1:0]  mrg_data;
    logic [M-1:0]  mrg_keep;
    logic [W-1:0]  pld_data;
    logic [M-1:0]  pld_keep;
    logic          pld_last;
    logic [PW-1:0] pld_in;
    logic [PW-1:0] pld_out;

    assign accept     = vld_in & rdy_out;
    assign busy       = (cnt_q != '0);
    assign is_end     = ((RW'(cnt_q) + RW'(1)) == r_use);
    assign close      = accept & (is_end | last_in | flush_in);
    assign flush_only = ~accept & flush_in & busy & rdy_out;
    assign load       = close | flush_only;

    // Effective ratio: out-of-range config means a full word; held mid-word.
    always_comb begin
        r_cfg = cfg_ratio;
        if (cfg_ratio == '0 || cfg_ratio > RMAX) begin
            r_cfg = RMAX;
        end
        r_use = (cnt_q == '0) ? r_cfg : r_q;
    end

    // Lane slot for the current count, mirrored for MSB-first fill.
    always_comb begin
        idx = cnt_q;
        if (LANE_ORDER == MSB_FIRST) begin
            idx = CW'(M-1) - cnt_q;
        end
    end

    // Merge the incoming lane into the partial word.
    always_comb begin
        mrg_data = acc_q;
        mrg_keep = keep_q;
        for (int l = 0; l < M; l++) begin
            if (CW'(l) == idx) begin
                mrg_data[l*N +: N] = data_in;
                mrg_keep[l]        = 1'b1;
            end
        end
    end

    // Word presented to the output register when a close happens.
    always_comb begin
        pld_data = acc_q;
        pld_keep = keep_q;
        pld_last = 1'b0;
        if (accept) begin
            pld_data = mrg_data;
            pld_keep = mrg_keep;
            pld_last = last_in;
        end
    end

    // Accumulator, lane counter and ratio next state.
    always_comb begin
        cnt_d  = cnt_q;
        r_d    = r_q;
        acc_d  = acc_q;
        keep_d = keep_q;
        if (accept && cnt_q == '0) begin
            r_d = r_cfg;
        end
        if (load) begin
            cnt_d  = '0;
            acc_d  = '0;
            keep_d = '0;
        end else if (accept) begin
            cnt_d  = cnt_q + CW'(1);
            acc_d  = mrg_data;
            keep_d = mrg_keep;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            r_q    <= RMAX;
            acc_q  <= '0;
            keep_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            r_q    <= r_d;
            acc_q  <= acc_d;
            keep_q <= keep_d;
        end
    end

    assign pld_in = {pld_last, pld_keep, pld_data};

    stream_out_reg #(
        .W(PW)
    ) u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(load),
        .pld_i (pld_in),
        .rdy_i (rdy_in),
        .vld_o (vld_out),
        .pld_o (pld_out),
        .rdy_o (rdy_out)
    );

    assign data_out = pld_out[W-1:0];
    assign keep_out = pld_out[W +: M];
    assign last_out = pld_out[PW-1];

endmodule

// File: tb/tb_snd_rcv_packer.sv
// Directed bench for snd_rcv_packer, LSB- and MSB-first instances side by side.
// A lane-queue model predicts every word; literal checks pin key results.
module tb_snd_rcv_packer;
    import stream_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  cfg_ratio;
    logic        vld_in;
    logic [7:0]  data_in;
    logic        last_in;
    logic        flush_in;
    logic        rdy_in;

    logic        rdy_a, vld_a, last_a, busy_a;
    logic [31:0] data_a;
    logic [3:0]  keep_a;
    logic        rdy_b, vld_b, last_b, busy_b;
    logic [31:0] data_b;
    logic [3:0]  keep_b;

    int nerr = 0;
    int nchk = 0;

    int m_lanes[$];
    int m_word[$];
    int m_R;
    bit m_vld;
    bit m_last;

    snd_rcv_packer #(.N(8), .M(4), .LANE_ORDER(LSB_FIRST)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_ratio(cfg_ratio),
        .vld_in(vld_in), .data_in(data_in), .last_in(last_in),
        .rdy_out(rdy_a), .flush_in(flush_in), .vld_out(vld_a),
        .data_out(data_a), .keep_out(keep_a), .last_out(last_a),
        .rdy_in(rdy_in), .busy(busy_a)
    );

    snd_rcv_packer #(.N(8), .M(4), .LANE_ORDER(MSB_FIRST)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_ratio(cfg_ratio),
        .vld_in(vld_in), .data_in(data_in), .last_in(last_in),
        .rdy_out(rdy_b), .flush_in(flush_in), .vld_out(vld_b),
        .data_out(data_b), .keep_out(keep_b), .last_out(last_b),
        .rdy_in(rdy_in), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int norm(input int c);
        return (c == 0 || c > 4) ? 4 : c;
    endfunction

    task automatic model_clear();
        m_lanes.delete();
        m_word.delete();
        m_vld  = 1'b0;
        m_last = 1'b0;
        m_R    = 4;
    endtask

    task automatic model_step();
        bit rdy;
        bit acc;
        bit emit;
        bit el;
        rdy  = !m_vld || rdy_in;
        acc  = vld_in && rdy;
        emit = 1'b0;
        el   = 1'b0;
        if (acc) begin
            if (m_lanes.size() == 0) m_R = norm(int'(cfg_ratio));
            m_lanes.push_back(int'(data_in));
            if (m_lanes.size() == m_R || last_in || flush_in) begin
                emit = 1'b1;
                el   = last_in;
            end
        end else if (flush_in && m_lanes.size() > 0 && rdy) begin
            emit = 1'b1;
        end
        if (emit) begin
            m_word = m_lanes;
            m_lanes.delete();
            m_last = el;
            m_vld  = 1'b1;
        end else if (m_vld && rdy_in) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic build(input bit msb, output logic [31:0] d,
                         output logic [3:0] k);
        int p;
        d = '0;
        k = '0;
        foreach (m_word[i]) begin
            p = msb ? 3 - i : i;
            d[p*8 +: 8] = m_word[i][7:0];
            k[p] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [31:0] d;
        logic [3:0]  k;
        logic        er;
        er = !m_vld || rdy_in;
        chk("rdy_a", 32'(rdy_a), 32'(er));
        chk("rdy_b", 32'(rdy_b), 32'(er));
        chk("vld_a", 32'(vld_a), 32'(m_vld));
        chk("vld_b", 32'(vld_b), 32'(m_vld));
        chk("busy_a", 32'(busy_a), 32'(m_lanes.size() != 0));
        chk("busy_b", 32'(busy_b), 32'(m_lanes.size() != 0));
        if (m_vld) begin
            build(1'b0, d, k);
            chk("data_a", data_a, d);
            chk("keep_a", 32'(keep_a), 32'(k));
            chk("last_a", 32'(last_a), 32'(m_last));
            build(1'b1, d, k);
            chk("data_b", data_b, d);
            chk("keep_b", 32'(keep_b), 32'(k));
            chk("last_b", 32'(last_b), 32'(m_last));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic lane(input logic [7:0] d, input bit l, input bit f);
        vld_in   = 1'b1;
        data_in  = d;
        last_in  = l;
        flush_in = f;
        cyc();
        vld_in   = 1'b0;
        last_in  = 1'b0;
        flush_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_vld", 32'({vld_a, vld_b}), 32'(0));
        chk("rst_data_a", data_a, 32'h0);
        chk("rst_data_b", data_b, 32'h0);
        chk("rst_keep", 32'({keep_a, keep_b}), 32'(0));
        chk("rst_last", 32'({last_a, last_b}), 32'(0));
        chk("rst_busy", 32'({busy_a, busy_b}), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        cfg_ratio = 3'd4;
        vld_in    = 1'b0;
        data_in   = '0;
        last_in   = 1'b0;
        flush_in  = 1'b0;
        rdy_in    = 1'b1;
        model_clear();
        @(negedge clk);
        reset_pulse();
        idle(1);

        // basic packing
        lane(8'h11, 0, 0);
        lane(8'h22, 0, 0);
        lane(8'h33, 0, 0);
        lane(8'h44, 0, 0);
        chk("basic_data", data_a, 32'h44332211);
        chk("basic_keep", 32'(keep_a), 32'hF);
        chk("basic_last", 32'(last_a), 32'h0);
        chk("basic_msb", data_b, 32'h11223344);

        // last_in closes early
        lane(8'hAA, 0, 0);
        lane(8'hBB, 1, 0);
        chk("last_data", data_a, 32'h0000BBAA);
        chk("last_keep", 32'(keep_a), 32'h3);
        chk("last_flag", 32'(last_a), 32'h1);
        chk("last_msb", data_b, 32'hAABB0000);

        // ratio 2, MSB-first words
        cfg_ratio = 3'd2;
        lane(8'h01, 0, 0);
        lane(8'h02, 0, 0);
        chk("msb_w0", data_b, 32'h01020000);
        chk("msb_k0", 32'(keep_b), 32'hC);
        lane(8'h03, 0, 0);
        lane(8'h04, 0, 0);
        chk("msb_w1", data_b, 32'h03040000);
        chk("msb_k1", 32'(keep_b), 32'hC);
        idle(1);

        // backpressure
        cfg_ratio = 3'd4;
        rdy_in = 1'b0;
        lane(8'hC1, 0, 0);
        lane(8'hC2, 0, 0);
        lane(8'hC3, 0, 0);
        lane(8'hC4, 0, 0);
        vld_in  = 1'b1;
        data_in = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_rdy", 32'(rdy_a), 32'h0);
            chk("bp_data", data_a, 32'hC4C3C2C1);
        end
        vld_in = 1'b0;
        rdy_in = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(rdy_a), 32'h1);
        chk("bp_release_vld", 32'(vld_a), 32'h1);
        cyc();
        chk("bp_taken", 32'(vld_a), 32'h0);

        // flush a partial word, then flush with nothing held
        lane(8'h55, 0, 0);
        lane(8'h66, 0, 0);
        flush_in = 1'b1;
        cyc();
        chk("fl_data", data_a, 32'h00006655);
        chk("fl_keep", 32'(keep_a), 32'h3);
        chk("fl_last", 32'(last_a), 32'h0);
        chk("fl_busy", 32'(busy_a), 32'h0);
        cyc();
        flush_in = 1'b0;
        chk("fl_noop", 32'(vld_a), 32'h0);

        // reset mid-word
        lane(8'hD1, 0, 0);
        lane(8'hD2, 0, 0);
        lane(8'hD3, 0, 0);
        reset_pulse();
        idle(2);
        chk("rst_quiet", 32'(vld_a), 32'h0);
        lane(8'h01, 0, 0);
        lane(8'h02, 0, 0);
        lane(8'h03, 0, 0);
        lane(8'h04, 0, 0);
        chk("rst_clean", data_a, 32'h04030201);
        chk("rst_keep_f", 32'(keep_a), 32'hF);

        // ratio 1, back-to-back single-lane words
        cfg_ratio = 3'd1;
        lane(8'h9A, 0, 0);
        chk("r1_w0", data_a, 32'h0000009A);
        lane(8'h9B, 0, 0);
        chk("r1_w1", data_a, 32'h0000009B);
        chk("r1_keep", 32'(keep_b), 32'h8);

        // out-of-range ratios act as full width
        cfg_ratio = 3'd0;
        lane(8'hE1, 0, 0);
        cfg_ratio = 3'd7;
        lane(8'hE2, 0, 0);
        lane(8'hE3, 0, 0);
        lane(8'hE4, 0, 0);
        chk("r0_data", data_a, 32'hE4E3E2E1);

        // ratio held mid-word despite cfg change
        cfg_ratio = 3'd2;
        lane(8'h71, 0, 0);
        cfg_ratio = 3'd4;
        lane(8'h72, 0, 0);
        chk("r_hold", data_a, 32'h00007271);
        idle(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/snd_rcv_packer.md
SND_RCV_PACKER -- requirements
Module: snd_rcv_packer

Interface
REQ-001 SHALL have parameter N, default 8, lane width in bits (N >= 1).
REQ-002 SHALL have parameter M, default 4, maximum lanes per output word (M >= 2).
REQ-003 SHALL have parameter LANE_ORDER, default LSB_FIRST, fill order (LSB_FIRST or MSB_FIRST).
REQ-004 SHALL have port clk, input, 1, clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_ratio, input, $clog2(M+1), lanes per word at run time.
REQ-007 SHALL have port vld_in, input, 1, upstream lane valid.
REQ-008 SHALL have port data_in, input, N, upstream lane data.
REQ-009 SHALL have port last_in, input, 1, lane closes the current word.
REQ-010 SHALL have port rdy_out, output, 1, ready to upstream.
REQ-011 SHALL have port flush_in, input, 1, close a partial word with no new lane.
REQ-012 SHALL have port vld_out, output, 1, downstream word valid.
REQ-013 SHALL have port data_out, output, M*N, packed word.
REQ-014 SHALL have port keep_out, output, M, per-lane valid mask.
REQ-015 SHALL have port last_out, output, 1, word was closed by last_in.
REQ-016 SHALL have port rdy_in, input, 1, downstream ready.
REQ-017 SHALL have port busy, output, 1, partial word held in the accumulator.

Function
REQ-018 SHALL hold an accumulator, lane counter cnt (0..M-1) and effective ratio R, plus one output register {data, keep, last, vld}.
REQ-019 SHALL latch R from cfg_ratio only when cnt==0 at an accept; cfg_ratio 0 or >M SHALL be treated as M.
REQ-020 SHALL drive rdy_out = ~vld_out | rdy_in (a combinational rdy_in->rdy_out path is permitted); rdy_out SHALL NOT depend on vld_in, last_in or flush_in.
REQ-021 SHALL accept a lane when vld_in & rdy_out, writing data_in to lane cnt (LSB_FIRST: bits [cnt*N +: N]) or to lane M-1-cnt (MSB_FIRST).
REQ-022 SHALL close the word on an accept when cnt==R-1, last_in=1, or flush_in=1, load the output register on the next edge (latency 1 cycle), and return cnt to 0.
REQ-023 SHALL set keep_out to the filled lanes and zero the data and keep bits of unfilled lanes.
REQ-024 SHALL set last_out=1 only when the closing accept had last_in=1.
REQ-025 SHALL, when flush_in=1 with no accept, cnt>0 and (~vld_out|rdy_in), emit the partial word with last_out=0 and return cnt to 0.
REQ-026 SHALL treat flush_in with cnt==0 and no accept as a no-op.
REQ-027 SHALL hold vld_out, data_out, keep_out and last_out stable while vld_out & ~rdy_in.
REQ-028 SHALL clear vld_out after a cycle with vld_out & rdy_in unless a new word loads in the same edge, so back-to-back words reach full throughput of one word per R accepts.
REQ-029 SHALL drive busy = (cnt != 0).
REQ-030 SHALL treat R==1 with last_in=0 as a full word: every lane is emitted with keep_out having one bit set.

Reset
REQ-031 SHALL, with rst_n low, asynchronously clear cnt, R (to M), the accumulator and all output-register fields, so vld_out=0, data_out=0, keep_out=0, last_out=0 and busy=0.
REQ-032 SHALL discard a partial word when reset is asserted mid-word, with nothing emitted after release.
REQ-033 SHALL have the first accept after release start at lane 0.

Structure
REQ-034 SHALL define the lane_order_e enum (LSB_FIRST, MSB_FIRST) in the shared package stream_pkg.
REQ-035 SHALL implement the output register/handshake as the sub-module stream_out_reg (payload width parameterised), instanced once.
REQ-036 SHALL keep the lane write and the keep/ratio logic in the top module.

Verification
All scenarios use N=8, M=4.
REQ-037 SHALL test basic packing: cfg_ratio=4, LSB_FIRST, accept lanes 11,22,33,44, rdy_in=1 -> one cycle later data_out=0x44332211, keep_out=4'b1111, last_out=0.
REQ-038 SHALL test last_in packing: lanes AA,BB with last_in on BB -> data_out=0x0000BBAA, keep_out=4'b0011, last_out=1.
REQ-039 SHALL test MSB_FIRST ordering: cfg_ratio=2, MSB_FIRST, lanes 01,02,03,04 -> two words 0x01020000 then 0x03040000, keep_out=4'b1100 each.
REQ-040 SHALL test backpressure: word pending and rdy_in=0 for 5 cycles -> rdy_out=0, outputs stable; rdy_in=1 -> word taken and rdy_out=1 in the same cycle.
REQ-041 SHALL test flush: lanes 55,66 then flush_in=1 with vld_in=0 -> data_out=0x00006655, keep_out=4'b0011, last_out=0, busy=0.
REQ-042 SHALL test reset mid-word: 3 lanes accepted, then rst_n pulse -> vld_out stays 0; next 4 lanes form a clean word starting at lane 0.
